// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline writeback with queued
// long-latency returns, exporting a pending-destination mask and a starvation stall.
module wb_write_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic        lat_valid,
  input  logic [4:0]  lat_wa,
  input  logic [31:0] lat_wd,
  output logic        lat_ready,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic        we,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

  logic [4:0]    fifo_wa [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          full, empty;
  logic          push, pop;
  logic          sel_stall, sel_pipe, sel_fifo;
  logic          lose;

  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic          we_q, we_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;

  logic [AW-1:0] offset;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign count  = wr_ptr_q - rd_ptr_q;

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  assign lat_ready = !full;
  // A zero destination still completes the handshake but is never stored.
  assign push      = lat_valid && !full && (lat_wa != 5'd0);

  // Arbitration priority: starved head, then pipeline, then idle-slot drain.
  always_comb begin
    sel_stall = stall_q && !empty;
    sel_pipe  = !sel_stall && pipe_we && (pipe_wa != 5'd0);
    sel_fifo  = !sel_stall && !sel_pipe && !empty;
    pop       = sel_stall || sel_fifo;
  end

  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (pop) begin
      we_d = 1'b1;
      wa_d = fifo_wa[rd_idx];
      wd_d = fifo_wd[rd_idx];
    end else if (sel_pipe) begin
      we_d = 1'b1;
      wa_d = pipe_wa;
      wd_d = pipe_wd;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Non-empty without a pop means the pipeline won this edge.
  assign lose = !empty && !pop;

  always_comb begin
    starve_d = '0;
    if (lose) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + SW'(1);
    end
    stall_d = (starve_d == StarveMax);
  end

  always_comb begin
    busy_mask = '0;
    offset    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - rd_idx;
      if ({1'b0, offset} < count) begin
        busy_mask[fifo_wa[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (push) begin
      fifo_wa[wr_idx] <= lat_wa;
      fifo_wd[wr_idx] <= lat_wd;
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign we        = we_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign stall_req = stall_q;

endmodule
